// File: rtl/spi_lcd_rx.sv
// SPI mode-0 target capturing the LCD byte stream (byte + D/C flag) into a show-ahead FIFO.
// Optional macro SPI_LCD_RX_FRAME_STATS_EN enables the per-frame byte counter on frame_bytes.
module spi_lcd_rx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  input  logic        lcd_dc,
  output logic [7:0]  rx_data,
  output logic        rx_dc,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        overflow,
  input  logic        overflow_clr,
  output logic        busy,
  output logic [7:0]  abort_count,
  output logic [15:0] frame_bytes
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_e;

  // Input synchronizers reset to idle bus levels so reset release creates no edges
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q, dc_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, mosi_s, cs_s, dc_s;
  logic                   sclk_rise, cs_fall, cs_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      dc_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], lcd_dc};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign dc_s      = dc_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  shreg_q;
  logic        push_q;
  logic [8:0]  push_dat_q;
  logic [7:0]  abort_q;
  logic        busy_q;
  logic        byte_done;

  // cs_rise takes priority over a coincident sclk edge
  assign byte_done = (state_q == SHIFT) && !cs_rise && sclk_rise && (bit_cnt_q == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      push_q     <= 1'b0;
      push_dat_q <= '0;
      abort_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      push_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q   <= SHIFT;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (bit_cnt_q != 3'd0 && abort_q != 8'hFF) abort_q <= abort_q + 8'd1;
          end else if (sclk_rise) begin
            shreg_q   <= {shreg_q[5:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              push_q     <= 1'b1;
              push_dat_q <= {dc_s, shreg_q, mosi_s};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Receive FIFO: binary pointers with a wrap bit, show-ahead head
  logic [8:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        ovf_q;
  logic        empty, full, pop, wr_en, ovf_set;
  logic [8:0]  head;

  assign empty   = (wptr_q == rptr_q);
  assign full    = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
  assign pop     = !empty && rx_ready;
  assign wr_en   = push_q && (!full || pop);
  assign ovf_set = push_q && full && !pop;
  assign head    = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= push_dat_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
      if (ovf_set)           ovf_q <= 1'b1;
      else if (overflow_clr) ovf_q <= 1'b0;
    end
  end

`ifdef SPI_LCD_RX_FRAME_STATS_EN
  logic [15:0] fbytes_q;

  // Counts every completed byte, dropped ones included
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  fbytes_q <= '0;
    else if (state_q == IDLE && cs_fall)        fbytes_q <= '0;
    else if (byte_done && fbytes_q != 16'hFFFF) fbytes_q <= fbytes_q + 16'd1;
  end

  assign frame_bytes = fbytes_q;
`else
  assign frame_bytes = '0;
`endif

  assign rx_valid    = !empty;
  assign rx_data     = rx_valid ? head[7:0] : 8'h00;
  assign rx_dc       = rx_valid ? head[8] : 1'b0;
  assign overflow    = ovf_q;
  assign busy        = busy_q;
  assign abort_count = abort_q;

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Directed bench for spi_lcd_rx: SPI driven at clk/8, outputs sampled on the falling clk edge.
module tb_spi_lcd_rx;
  logic        clk = 1'b0;
  logic        reset, spi_clk, spi_mosi, spi_cs_n, lcd_dc;
  logic [7:0]  rx_data;
  logic        rx_dc, rx_valid, rx_ready, overflow, overflow_clr, busy;
  logic [7:0]  abort_count;
  logic [15:0] frame_bytes;

  int   errs = 0;
  int   checks = 0;
  logic v3, v4;

  spi_lcd_rx #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .lcd_dc(lcd_dc), .rx_data(rx_data), .rx_dc(rx_dc),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .overflow(overflow),
    .overflow_clr(overflow_clr), .busy(busy), .abort_count(abort_count),
    .frame_bytes(frame_bytes)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end

  task automatic cs_lo();
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_hi();
    repeat (2) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i]; lcd_dc = dc;
      repeat (4) @(negedge clk);
      spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  // Last bit records rx_valid 3 and 4 cycles after raising sclk; optionally pops in the push cycle
  task automatic send_byte(input logic [7:0] b, input logic dc, input logic pop_at_push);
    send_bits(b, 7, dc);
    spi_mosi = b[0]; lcd_dc = dc;
    repeat (4) @(negedge clk);
    spi_clk = 1'b1;
    repeat (3) @(negedge clk);
    v3 = rx_valid;
    if (pop_at_push) rx_ready = 1'b1;
    @(negedge clk);
    v4 = rx_valid;
    if (pop_at_push) rx_ready = 1'b0;
    spi_clk = 1'b0;
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({rx_valid, rx_dc, overflow, busy} !== 4'b0) begin errs++;
      $display("FAIL reset_flags got=%b exp=0000", {rx_valid, rx_dc, overflow, busy}); end
    checks++; if ({rx_data, abort_count, frame_bytes} !== 32'h0) begin errs++;
      $display("FAIL reset_values got=%h exp=00000000", {rx_data, abort_count, frame_bytes}); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({rx_valid, busy} !== 2'b00) begin errs++;
      $display("FAIL reset_release got=%b exp=00", {rx_valid, busy}); end
  endtask

  task automatic test_basic();
    cs_lo();
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy got=%b exp=1", busy); end
    send_byte(8'hA5, 1'b1, 1'b0);
    checks++; if ({v3, v4} !== 2'b01) begin errs++;
      $display("FAIL basic_latency got=%b exp=01", {v3, v4}); end
    cs_hi();
    checks++; if ({rx_valid, rx_dc, rx_data} !== {2'b11, 8'hA5}) begin errs++;
      $display("FAIL basic_entry got=%b/%b/%h exp=1/1/a5", rx_valid, rx_dc, rx_data); end
    checks++; if ({busy, abort_count} !== 9'h0) begin errs++;
      $display("FAIL basic_idle got busy=%b abort=%0d exp 0/0", busy, abort_count); end
    pop_one();
    checks++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL basic_pop got=%b exp=0", rx_valid); end
  endtask

  task automatic test_multi();
    rx_ready = 1'b0;
    cs_lo();
    send_byte(8'h2C, 1'b0, 1'b0);
    send_byte(8'h12, 1'b1, 1'b0);
    send_byte(8'h34, 1'b1, 1'b0);
    cs_hi();
    checks++; if ({rx_valid, rx_dc, rx_data} !== {2'b10, 8'h2C}) begin errs++;
      $display("FAIL multi_e0 got=%b/%b/%h exp=1/0/2c", rx_valid, rx_dc, rx_data); end
    repeat (5) @(negedge clk);
    checks++; if ({rx_dc, rx_data} !== {1'b0, 8'h2C}) begin errs++;
      $display("FAIL multi_hold got=%b/%h exp=0/2c", rx_dc, rx_data); end
    pop_one();
    checks++; if ({rx_valid, rx_dc, rx_data} !== {2'b11, 8'h12}) begin errs++;
      $display("FAIL multi_e1 got=%b/%b/%h exp=1/1/12", rx_valid, rx_dc, rx_data); end
    @(negedge clk);
    checks++; if ({rx_dc, rx_data} !== {1'b1, 8'h12}) begin errs++;
      $display("FAIL multi_e1_hold got=%b/%h exp=1/12", rx_dc, rx_data); end
    pop_one();
    checks++; if ({rx_valid, rx_dc, rx_data} !== {2'b11, 8'h34}) begin errs++;
      $display("FAIL multi_e2 got=%b/%b/%h exp=1/1/34", rx_valid, rx_dc, rx_data); end
    pop_one();
    checks++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL multi_empty got=%b exp=0", rx_valid); end
  endtask

  task automatic test_abort();
    cs_lo();
    send_bits(8'hFF, 5, 1'b1);
    cs_hi();
    checks++; if ({rx_valid, busy, abort_count} !== 10'h001) begin errs++;
      $display("FAIL abort_one got valid=%b busy=%b abort=%0d exp 0/0/1", rx_valid, busy, abort_count); end
    for (int k = 0; k < 299; k++) begin
      cs_lo();
      send_bits(8'h80, 1, 1'b0);
      cs_hi();
    end
    checks++; if (abort_count !== 8'd255) begin errs++;
      $display("FAIL abort_sat got=%0d exp=255", abort_count); end
  endtask

  task automatic test_overflow();
    rx_ready = 1'b0;
    cs_lo();
    for (int k = 0; k < 17; k++) send_byte(8'(k), 1'b1, 1'b0);
    cs_hi();
    checks++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    for (int k = 0; k < 16; k++) begin
      checks++; if ({rx_valid, rx_data} !== {1'b1, 8'(k)}) begin errs++;
        $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", k, rx_valid, rx_data, 8'(k)); end
      pop_one();
    end
    checks++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL ovf_empty got=%b exp=0", rx_valid); end
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    cs_lo();
    for (int k = 0; k < 16; k++) send_byte(8'h20 + 8'(k), 1'b0, 1'b0);
    send_byte(8'h30, 1'b0, 1'b1);
    cs_hi();
    checks++; if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_poppush got=%b exp=0", overflow); end
    for (int k = 1; k < 17; k++) begin
      checks++; if ({rx_valid, rx_dc, rx_data} !== {2'b10, 8'h20 + 8'(k)}) begin errs++;
        $display("FAIL ovf_drain2_%0d got=%b/%b/%h exp=1/0/%h", k, rx_valid, rx_dc, rx_data, 8'h20 + 8'(k)); end
      pop_one();
    end
    checks++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL ovf_empty2 got=%b exp=0", rx_valid); end
  endtask

  task automatic test_reset_mid();
    cs_lo();
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h33, 1'b1, 1'b0);
    send_bits(8'hF0, 4, 1'b1);
    spi_clk = 1'b0; spi_cs_n = 1'b1; reset = 1'b1;
    @(negedge clk);
    checks++; if ({rx_valid, rx_dc, overflow, busy, rx_data, abort_count, frame_bytes} !== 36'h0) begin errs++;
      $display("FAIL rstmid_outputs got valid=%b busy=%b data=%h abort=%0d fb=%0d exp all 0",
               rx_valid, busy, rx_data, abort_count, frame_bytes); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    cs_lo();
    send_byte(8'h5A, 1'b0, 1'b0);
    cs_hi();
    checks++; if ({rx_valid, rx_dc, rx_data} !== {2'b10, 8'h5A}) begin errs++;
      $display("FAIL rstmid_frame got=%b/%b/%h exp=1/0/5a", rx_valid, rx_dc, rx_data); end
    checks++; if ({busy, abort_count} !== 9'h0) begin errs++;
      $display("FAIL rstmid_idle got busy=%b abort=%0d exp 0/0", busy, abort_count); end
    pop_one();
    checks++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL rstmid_empty got=%b exp=0", rx_valid); end
  endtask

  task automatic test_frame_stats();
    rx_ready = 1'b1;
    cs_lo();
    for (int k = 0; k < 10; k++) send_byte(8'h40 + 8'(k), 1'b1, 1'b0);
    cs_hi();
    rx_ready = 1'b0;
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL stats_drained got=%b exp=0", rx_valid); end
`ifdef SPI_LCD_RX_FRAME_STATS_EN
    checks++; if (frame_bytes !== 16'd10) begin errs++; $display("FAIL stats_count got=%0d exp=10", frame_bytes); end
    repeat (20) @(negedge clk);
    checks++; if (frame_bytes !== 16'd10) begin errs++; $display("FAIL stats_hold got=%0d exp=10", frame_bytes); end
`else
    checks++; if (frame_bytes !== 16'd0) begin errs++; $display("FAIL stats_off got=%0d exp=0", frame_bytes); end
`endif
    cs_lo();
    checks++; if (frame_bytes !== 16'd0) begin errs++; $display("FAIL stats_clear got=%0d exp=0", frame_bytes); end
    cs_hi();
    checks++; if (abort_count !== 8'd0) begin errs++; $display("FAIL stats_noabort got=%0d exp=0", abort_count); end
  endtask

  initial begin
    reset = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1; lcd_dc = 1'b0;
    rx_ready = 1'b0; overflow_clr = 1'b0; v3 = 1'b0; v4 = 1'b0;
    test_reset();
    test_basic();
    test_multi();
    test_abort();
    test_overflow();
    test_reset_mid();
    test_frame_stats();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
